// File: rtl/rr_mux4to1_if.sv
// rr_mux4to1_if
// Bundles the four producer channels and the single consumer channel of
// rr_mux4to1 into one interface.
//
// Signals:
//   en         grant enable (producer side control)
//   x0..x3     channel data, WIDTH bits each
//   in_valid   per-channel valid, bit i for channel i
//   in_ready   per-channel take strobe, at most one bit set
//   y          registered output data
//   out_sel    source channel index of y
//   out_valid  y/out_sel hold a word
//   out_ready  consumer accepts the word this cycle
//
// Modports:
//   slave   view used by the multiplexer itself
//   master  view used by whatever drives the producers and consumes the output

interface rr_mux4to1_if #(
   parameter int WIDTH = 8
);

   logic             en;
   logic [WIDTH-1:0] x0;
   logic [WIDTH-1:0] x1;
   logic [WIDTH-1:0] x2;
   logic [WIDTH-1:0] x3;
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [WIDTH-1:0] y;
   logic [1:0]       out_sel;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  en,
      input  x0,
      input  x1,
      input  x2,
      input  x3,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output y,
      output out_sel,
      output out_valid
   );

   modport master (
      output en,
      output x0,
      output x1,
      output x2,
      output x3,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  y,
      input  out_sel,
      input  out_valid
   );

endinterface

// File: rtl/rr_mux4to1.sv
// rr_mux4to1
// Registered 4-to-1 multiplexer with round-robin arbitration. Four producer
// streams are merged onto one valid/ready output; every word is tagged with
// its source channel on out_sel so a downstream demultiplexer can route it
// back.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_mux4to1_if.slave (en, x0..x3, in_valid, in_ready,
//          y, out_sel, out_valid, out_ready)
//
// Build option:
//   RR_MUX_FIXED_PRIO_EN  when defined, the search always starts at channel 0
//                         (fixed priority, channel 0 highest) and the
//                         round-robin pointer is not built. Handshake,
//                         latency and reset behaviour are unchanged.
//
// Output stage states:
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_EMPTY | output register holds no word, out_valid = 0
//   ST_FULL  | output register holds a word,  out_valid = 1

module rr_mux4to1 #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_mux4to1_if.slave    bus
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] y_d;
   logic [1:0]       sel_q;
   logic [1:0]       sel_d;

   logic [WIDTH-1:0] x_arr [4];
   logic [1:0]       start_idx;
   logic [1:0]       grant_idx;
   logic             grant_found;
   logic             out_valid;
   logic             drain;
   logic             load;

   assign x_arr[0] = bus.x0;
   assign x_arr[1] = bus.x1;
   assign x_arr[2] = bus.x2;
   assign x_arr[3] = bus.x3;

`ifdef RR_MUX_FIXED_PRIO_EN
   assign start_idx = 2'd0;
`else
   logic [1:0] ptr_q;
   logic [1:0] ptr_d;

   assign start_idx = ptr_q;
`endif

   // Circular search from start_idx; the 2-bit index wraps 3 -> 0 naturally.
   always_comb begin
      logic [1:0] idx;
      idx         = 2'd0;
      grant_found = 1'b0;
      grant_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = start_idx + 2'(k);
         if (!grant_found && bus.in_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign drain     = out_valid & bus.out_ready;

   // rst_n gates load so in_ready is quiet throughout reset even though the
   // arbiter itself is purely combinational on in_valid.
   assign load = rst_n & bus.en & ((state_q == ST_EMPTY) | drain) & grant_found;

   assign bus.in_ready  = load ? (4'b0001 << grant_idx) : 4'b0000;
   assign bus.y         = y_q;
   assign bus.out_sel   = sel_q;
   assign bus.out_valid = out_valid;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      sel_d   = sel_q;

      case (state_q)
         ST_EMPTY: begin
            if (load) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // A load in the same cycle as a drain replaces the word with no bubble.
            if (load) begin
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      if (load) begin
         y_d   = x_arr[grant_idx];
         sel_d = grant_idx;
      end
   end

`ifndef RR_MUX_FIXED_PRIO_EN
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = grant_idx + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         y_q     <= '0;
         sel_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         sel_q   <= sel_d;
      end
   end

endmodule

// File: tb/tb_rr_mux4to1.sv
// tb_rr_mux4to1
// Self-checking bench for rr_mux4to1: directed scenarios with literal
// expectations, followed by randomized traffic compared every cycle against
// a behavioural model of the arbiter and output register.

module tb_rr_mux4to1;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n;

   rr_mux4to1_if #(.WIDTH(WIDTH)) bus ();

   rr_mux4to1 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: one word slot plus the next channel to try first.
   bit         m_valid;
   logic [7:0] m_y;
   int         m_sel;
   int         m_ptr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] x_of(input int i);
      case (i)
         0:       return bus.x0;
         1:       return bus.x1;
         2:       return bus.x2;
         default: return bus.x3;
      endcase
   endfunction

   // Index of the channel the rules pick, or -1 when nothing is requesting.
   function automatic int model_grant();
      for (int k = 0; k < 4; k++) begin
         int c;
`ifdef RR_MUX_FIXED_PRIO_EN
         c = k;
`else
         c = (m_ptr + k) % 4;
`endif
         if (bus.in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit model_load();
      return bus.en && (!m_valid || bus.out_ready) && (model_grant() >= 0);
   endfunction

   function automatic logic [3:0] model_ready();
      if (model_load()) return 4'(1 << model_grant());
      return 4'b0000;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_y     = 8'h00;
      m_sel   = 0;
      m_ptr   = 0;
   endtask

   task automatic model_update();
      int g;
      g = model_grant();
      if (model_load()) begin
         m_y     = x_of(g);
         m_sel   = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % 4;
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all();
      check("in_ready",  {28'd0, bus.in_ready}, {28'd0, model_ready()});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("y",         {24'd0, bus.y}, {24'd0, m_y});
      check("out_sel",   {30'd0, bus.out_sel}, m_sel);
   endtask

   // Inputs are set by the caller just after a rising edge; compare, then
   // advance both DUT and model across one edge.
   task automatic step();
      #1;
      compare_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_x(input logic [7:0] base);
      bus.x0 = base;
      bus.x1 = base + 8'd1;
      bus.x2 = base + 8'd2;
      bus.x3 = base + 8'd3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      rst_n         = 1'b1;
      bus.en        = 1'b1;
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b1;
      set_x(8'h00);

      // Reset: outputs and in_ready are 0 even with every channel requesting.
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("rst_in_ready",  {28'd0, bus.in_ready}, 0);
      check("rst_y",         {24'd0, bus.y}, 0);

      @(posedge clk);
      #1;
      bus.in_valid = 4'b0000;
      rst_n        = 1'b1;
      step();
      step();
      check("idle_out_valid", {31'd0, bus.out_valid}, 0);
      check("idle_y",         {24'd0, bus.y}, 0);

`ifdef RR_MUX_FIXED_PRIO_EN
      bus.in_valid = 4'b1111;
      set_x(8'hA0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("fixed_sel", {30'd0, bus.out_sel}, 0);
         check("fixed_y",   {24'd0, bus.y}, 32'hA0);
      end
`else
      // All four busy: strict rotation 0,1,2,3,0,...
      bus.in_valid = 4'b1111;
      set_x(8'hA0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_sel",   {30'd0, bus.out_sel}, i % 4);
         check("rr_y",     {24'd0, bus.y}, 32'hA0 + i % 4);
         check("rr_valid", {31'd0, bus.out_valid}, 1);
      end

      // Last grant was 3: search wraps 0 -> 1 -> 2.
      bus.in_valid = 4'b0100;
      bus.x2       = 8'h5C;
      #1 check("wrap_ready", {28'd0, bus.in_ready}, 32'b0100);
      step();
      check("wrap_y",   {24'd0, bus.y}, 32'h5C);
      check("wrap_sel", {30'd0, bus.out_sel}, 2);

      // Load 0x11 from channel 3, then hold it under backpressure.
      bus.in_valid = 4'b1000;
      bus.x3       = 8'h11;
      step();
      check("bp_load_y", {24'd0, bus.y}, 32'h11);
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      set_x(8'h20);
      for (int i = 0; i < 3; i++) begin
         #1 check("bp_ready", {28'd0, bus.in_ready}, 0);
         step();
         check("bp_hold_y", {24'd0, bus.y}, 32'h11);
         check("bp_valid",  {31'd0, bus.out_valid}, 1);
      end
      bus.out_ready = 1'b1;
      #1 check("bp_release_ready", {28'd0, bus.in_ready}, 32'b0001);
      step();
      check("bp_nobubble_valid", {31'd0, bus.out_valid}, 1);
      check("bp_nobubble_y",     {24'd0, bus.y}, 32'h20);

      // Enable gating: held word drains, nothing new granted until en=1.
      bus.en        = 1'b0;
      bus.in_valid  = 4'b0010;
      bus.out_ready = 1'b0;
      #1 check("en_ready_hold", {28'd0, bus.in_ready}, 0);
      step();
      check("en_hold_valid", {31'd0, bus.out_valid}, 1);
      bus.out_ready = 1'b1;
      #1 check("en_ready_drain", {28'd0, bus.in_ready}, 0);
      step();
      check("en_drained_valid", {31'd0, bus.out_valid}, 0);
      #1 check("en_ready_idle", {28'd0, bus.in_ready}, 0);
      step();
      bus.en = 1'b1;
      #1 check("en_ready_on", {28'd0, bus.in_ready}, 32'b0010);
      step();
      check("en_y",   {24'd0, bus.y}, 32'h21);
      check("en_sel", {30'd0, bus.out_sel}, 1);
`endif

      // Reset mid-cycle while FULL: everything clears without a clock edge.
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
      check("midrst_y",         {24'd0, bus.y}, 0);
      check("midrst_sel",       {30'd0, bus.out_sel}, 0);
      check("midrst_in_ready",  {28'd0, bus.in_ready}, 0);
      model_reset();
      bus.in_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step();

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         bus.en        = ($urandom_range(0, 7) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid  = 4'($urandom);
         bus.x0        = 8'($urandom);
         bus.x1        = 8'($urandom);
         bus.x2        = 8'($urandom);
         bus.x3        = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_mux4to1.md
# rr_mux4to1

Registered 4-to-1 multiplexer with round-robin arbitration and valid/ready handshakes on every input channel and on the single output. It is the gathering counterpart to the 1-to-4 enabled demultiplexer: it merges four producer streams onto one channel and tags each word with its source index on `out_sel`. A downstream demultiplexer can drive its `sel` directly from `out_sel` to route each word back to a matching channel.

## Interface

Parameters:
- `WIDTH`, default 8: data width of each input channel and of the output.

Ports:
- `clk`  input  1  — system clock; all state updates on the rising edge.
- `rst_n`  input  1  — reset, asynchronous and active-low.
- `en`  input  1  — grant enable; when low, no new words are accepted.
- `x0`..`x3`  input  WIDTH each  — channel 0..3 data.
- `in_valid`  input  4  — bit i high means channel i holds a word.
- `in_ready`  output  4  — bit i high means channel i's word is taken this cycle; combinational, at most one bit set.
- `y`  output  WIDTH  — registered output data.
- `out_sel`  output  2  — index of the channel that produced `y`.
- `out_valid`  output  1  — `y`/`out_sel` hold a word.
- `out_ready`  input  1  — consumer accepts the word this cycle.

## Operation

- Output stage is a single register with two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load` = `en` & (EMPTY | (`out_valid` & `out_ready`)) & (|`in_valid`).
- Arbiter: round-robin search starting at pointer `ptr` (2 bits), checking `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 mod 4.
  - The first channel with `in_valid` set is granted as index g.
  - `in_ready[g]`=`load`; all other `in_ready` bits are 0.
- On `load`:
  - `y`←`x[g]`, `out_sel`←g, state→FULL.
  - `ptr`←g+1 mod 4; 3 wraps to 0.
- On `out_valid` & `out_ready` without `load`: state→EMPTY. `y` and `out_sel` hold their last values.
- Simultaneous drain and load: the register is replaced in the same cycle, the state stays FULL, and there is no bubble.
- FULL with `out_ready`=0: the register is held and all `in_ready` bits are 0 (backpressure).
- `en`=0 blocks new grants only. A word already in the register keeps `out_valid` high until the consumer accepts it. `ptr` is unchanged.
- `in_valid`=0000: no grant, `ptr` unchanged.
- Inputs must hold `x[i]` stable while `in_valid[i]`=1 and `in_ready[i]`=0. The block does not check this.

## Timing

- Reset values (asynchronous, on `rst_n` falling): `y`=0, `out_sel`=0, `out_valid`=0, `ptr`=0, state EMPTY. `in_ready`=0 while `rst_n`=0.
- Reset mid-transfer: the word in the register is discarded, with no partial output.
- Latency: word accepted at edge N appears with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while `out_ready`=1 and any input is valid.
- Fairness: with all four channels valid continuously, grants go 0,1,2,3,0,... Each channel waits at most 3 grants.
- `in_ready` depends combinationally on `in_valid`, `en`, `out_ready` and state. Nothing depends combinationally on `out_ready` → `out_valid`.

## Configuration

- Macro `RR_MUX_FIXED_PRIO_EN`.
- Defined: fixed priority. The search always starts at channel 0, so channel 0 is highest and channel 3 lowest. `ptr` is not implemented.
- Undefined (default): round-robin as described in Operation.
- All handshake, latency and reset behaviour is identical in both builds.

## Test plan

- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-cycle with `out_valid`=1.
  - Required: `out_valid`, `y`, `out_sel` and `in_ready` go to 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset with `in_valid`=0000.
  - Required: outputs stay 0.
- Round-robin, all busy:
  - Stimulus: `in_valid`=1111, x0..x3 = 8'hA0..8'hA3, `out_ready`=1, `en`=1, for 8 cycles.
  - Required: `out_sel` = 0,1,2,3,0,1,2,3 with `y` = A0,A1,A2,A3,A0,A1,A2,A3; `out_valid` high for all 8 cycles.
- Sparse request and wrap:
  - Stimulus: only channel 2 valid (x2=8'h5C) after a grant of channel 3.
  - Required: the search wraps 0→1→2; `in_ready`=0100, next `y`=5C, `out_sel`=2.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles while FULL (`y`=8'h11), with `in_valid`=1111.
  - Required: `in_ready`=0000 and `y`=11 held for all 3 cycles; the cycle `out_ready` rises, a new word loads with no bubble.
- Enable gating:
  - Stimulus: `en`=0 with `in_valid`=0010 and the register FULL; then `out_ready`=1.
  - Required: the held word drains and `out_valid` falls to 0; `in_ready` stays 0000 until `en`=1, then `in_ready`=0010.
- Fixed-priority build (`RR_MUX_FIXED_PRIO_EN` defined):
  - Stimulus: `in_valid`=1111 held for 4 cycles.
  - Required: `out_sel`=0 on all 4 cycles.
